// File: rtl/muldiv_pkg.sv
// Shared constants, FSM state type and operand helpers for the multiply/divide sequencer.
package muldiv_pkg;

    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

    localparam logic [4:0] ITER_LAST = 5'd31;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    function automatic logic is_muldiv(input logic [5:0] f);
        return (f == FUNCT_MULT) || (f == FUNCT_MULTU) ||
               (f == FUNCT_DIV)  || (f == FUNCT_DIVU);
    endfunction

    // Magnitude of a signed operand; -2^31 maps to 2^31, which still fits unsigned.
    function automatic logic [31:0] abs_if(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? -v : v;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply or restoring divide on a 64-bit accumulator.
module muldiv_step (
    input  logic        i_is_div,
    input  logic [63:0] i_acc,
    input  logic [31:0] i_operand,
    output logic [63:0] o_acc
);

    logic [32:0] w_sum;
    logic [32:0] w_trial;

    always_comb begin
        w_sum   = {1'b0, i_acc[63:32]} + (i_acc[0] ? {1'b0, i_operand} : 33'd0);
        // The shifted partial remainder can need 33 bits when the divisor exceeds 2^31.
        w_trial = i_acc[63:31] - {1'b0, i_operand};
        if (i_is_div) begin
            if (!w_trial[32]) begin
                o_acc = {w_trial[31:0], i_acc[30:0], 1'b1};
            end else begin
                o_acc = {i_acc[62:31], i_acc[30:0], 1'b0};
            end
        end else begin
            o_acc = {w_sum, i_acc[31:1]};
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning the architectural HI/LO registers.
module muldiv_seq
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [5:0]  funct,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_by_zero
);

    state_t      r_state;
    state_t      w_state_next;
    logic [4:0]  r_cnt;
    logic [63:0] r_acc;
    logic [31:0] r_operand;
    logic        r_is_div;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_dbz_op;
    logic        r_busy;
    logic        r_done;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_dbz;

    logic        w_accept;
    logic        w_div_req;
    logic        w_signed_req;
    logic        w_zero_div;
    logic [63:0] w_step_acc;
    logic [63:0] w_neg_acc;
    logic [31:0] w_fix_hi;
    logic [31:0] w_fix_lo;
    logic        w_busy_next;
    logic        w_done_next;

    assign w_div_req    = funct[1];
    assign w_signed_req = !funct[0];
    assign w_zero_div   = w_div_req && (operand_b == 32'd0);
    // flush beats a same-cycle start so an aborted instruction never launches.
    assign w_accept     = (r_state == IDLE) && start && is_muldiv(funct) && !flush;
    assign w_neg_acc    = -r_acc;

    muldiv_step u_step (
        .i_is_div  (r_is_div),
        .i_acc     (r_acc),
        .i_operand (r_operand),
        .o_acc     (w_step_acc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: if (w_accept) w_state_next = w_zero_div ? FIX : RUN;
            RUN: begin
                if (flush) begin
                    w_state_next = IDLE;
                end else if (r_cnt == ITER_LAST) begin
                    w_state_next = FIX;
                end
            end
            FIX:     w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_fix_hi = r_acc[63:32];
        w_fix_lo = r_acc[31:0];
        if (!r_dbz_op) begin
            if (!r_is_div) begin
                if (r_neg_q) {w_fix_hi, w_fix_lo} = w_neg_acc;
            end else begin
                if (r_neg_q) w_fix_lo = -r_acc[31:0];
                if (r_neg_r) w_fix_hi = -r_acc[63:32];
            end
        end
        w_busy_next = (w_state_next != IDLE);
        w_done_next = (r_state == FIX) && !flush;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= 5'd0;
            r_acc     <= 64'd0;
            r_operand <= 32'd0;
            r_is_div  <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_dbz_op  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_dbz     <= 1'b0;
        end else begin
            r_busy <= w_busy_next;
            r_done <= w_done_next;
            if (w_accept) begin
                r_cnt     <= 5'd0;
                r_is_div  <= w_div_req;
                r_dbz_op  <= w_zero_div;
                r_neg_q   <= w_signed_req && (operand_a[31] ^ operand_b[31]);
                r_neg_r   <= w_signed_req && operand_a[31];
                r_operand <= abs_if(operand_b, w_signed_req);
                r_dbz     <= 1'b0;
                // A zero divisor preloads the architectural fallback result for FIX.
                r_acc     <= w_zero_div ? {operand_a, 32'hFFFF_FFFF}
                                        : {32'd0, abs_if(operand_a, w_signed_req)};
            end else if ((r_state == RUN) && !flush) begin
                r_acc <= w_step_acc;
                r_cnt <= r_cnt + 5'd1;
            end
            if (w_done_next) begin
                r_hi  <= w_fix_hi;
                r_lo  <= w_fix_lo;
                r_dbz <= r_dbz_op;
            end
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign hi          = r_hi;
    assign lo          = r_lo;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed plus randomized checks of muldiv_seq against a plain-arithmetic reference model.
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [5:0]  funct;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_by_zero;

    int n_checks = 0;
    int n_pass   = 0;

    muldiv_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .funct       (funct),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .flush       (flush),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Returns {div_by_zero, hi, lo} computed with ordinary integer arithmetic.
    function automatic logic [64:0] ref_op(input logic [5:0] f, input logic [31:0] a,
                                           input logic [31:0] b);
        longint      sa;
        longint      sb;
        logic [63:0] p;
        logic [63:0] q;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (f)
            6'h18: begin p = sa * sb; return {1'b0, p}; end
            6'h19: begin p = {32'd0, a} * {32'd0, b}; return {1'b0, p}; end
            6'h1A: begin
                if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {1'b0, r[31:0], q[31:0]};
            end
            default: begin
                if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
                return {1'b0, a % b, a / b};
            end
        endcase
    endfunction

    task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b);
        logic [64:0] e;
        int          lat;
        int          n;
        e   = ref_op(f, a, b);
        lat = (f[1] && b == 32'd0) ? 1 : 33;
        @(negedge clk);
        start = 1'b1; funct = f; operand_a = a; operand_b = b;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        check({tag, "_busy0"}, {63'd0, busy}, 64'd1);
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        $display("op %s funct=%h a=%h b=%h -> hi=%h lo=%h dbz=%0d lat=%0d",
                 tag, f, a, b, hi, lo, div_by_zero, n);
        check({tag, "_lat"}, 64'(n), 64'(lat));
        check({tag, "_busy_at_done"}, {63'd0, busy}, 64'd0);
        check({tag, "_hilo"}, {hi, lo}, e[63:0]);
        check({tag, "_dbz"}, {63'd0, div_by_zero}, {63'd0, e[64]});
        @(negedge clk);
        check({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
    endtask

    logic [5:0]  f_a, f_b;
    logic [31:0] a_a, b_a, a_b, b_b;
    logic [64:0] e_ref;
    logic [31:0] corner [6];
    int          n, m;
    logic        saw_done;

    initial begin
        corner[0] = 32'h0000_0000; corner[1] = 32'h0000_0001; corner[2] = 32'hFFFF_FFFF;
        corner[3] = 32'h8000_0000; corner[4] = 32'h7FFF_FFFF; corner[5] = 32'h0000_0002;
        rst_n = 1'b0; start = 1'b0; flush = 1'b0; funct = 6'd0;
        operand_a = 32'd0; operand_b = 32'd0;
        #12;
        check("reset_outs", {busy, done, div_by_zero, hi, lo}, 67'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("mult_7x-3", 6'h18, 32'h0000_0007, 32'hFFFF_FFFD);
        check("mult_7x-3_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op("multu_max2", 6'h19, 32'hFFFF_FFFF, 32'h0000_0002);
        run_op("divu_100_7", 6'h1B, 32'd100, 32'd7);
        check("divu_100_7_const", {hi, lo}, {32'd2, 32'd14});
        run_op("div_-7_2", 6'h1A, 32'hFFFF_FFF9, 32'd2);
        run_op("div_min_m1", 6'h1A, 32'h8000_0000, 32'hFFFF_FFFF);
        check("div_min_m1_const", {hi, lo}, {32'd0, 32'h8000_0000});
        run_op("div_5_0", 6'h1A, 32'd5, 32'd0);
        run_op("mult_1x1", 6'h18, 32'd1, 32'd1);

        // Invalid funct and a start cancelled by flush must not launch anything.
        @(negedge clk);
        start = 1'b1; funct = 6'h20; operand_a = 32'd3; operand_b = 32'd3;
        @(negedge clk);
        check("bad_funct_idle", {63'd0, busy}, 64'd0);
        funct = 6'h18; flush = 1'b1;
        @(negedge clk);
        check("flush_beats_start", {63'd0, busy}, 64'd0);
        start = 1'b0; flush = 1'b0;

        // Start held with changing operands while busy; second op accepted on the done cycle.
        f_a = 6'h18; a_a = $urandom; b_a = $urandom;
        f_b = 6'h1B; a_b = $urandom; b_b = $urandom_range(1, 1000);
        @(negedge clk);
        start = 1'b1; funct = f_a; operand_a = a_a; operand_b = b_a;
        @(negedge clk);
        n = 0;
        while (!done && n < 40) begin
            funct = 6'h18 + 6'($urandom_range(0, 3));
            operand_a = $urandom; operand_b = $urandom;
            @(negedge clk);
            n++;
        end
        e_ref = ref_op(f_a, a_a, b_a);
        $display("held first -> hi=%h lo=%h lat=%0d", hi, lo, n);
        check("held_first_lat", 64'(n), 64'd33);
        check("held_first_hilo", {hi, lo}, e_ref[63:0]);
        funct = f_b; operand_a = a_b; operand_b = b_b;
        @(negedge clk);
        start = 1'b0;
        check("b2b_accepted", {63'd0, busy}, 64'd1);
        m = 0;
        while (!done && m < 40) begin
            @(negedge clk);
            m++;
        end
        e_ref = ref_op(f_b, a_b, b_b);
        $display("held second -> hi=%h lo=%h lat=%0d", hi, lo, m);
        check("b2b_lat", 64'(m), 64'd33);
        check("b2b_hilo", {hi, lo}, e_ref[63:0]);

        // Flush mid-run leaves the previous result intact and produces no done.
        run_op("divu_pre_flush", 6'h1B, 32'd100, 32'd7);
        @(negedge clk);
        start = 1'b1; funct = 6'h18; operand_a = 32'd9; operand_b = 32'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        $display("flush -> busy=%0d done=%0d hi=%h lo=%h", busy, done, hi, lo);
        check("flush_busy", {63'd0, busy}, 64'd0);
        check("flush_hilo", {hi, lo}, {32'd2, 32'd14});
        saw_done = done;
        repeat (40) begin
            @(negedge clk);
            saw_done = saw_done | done;
        end
        check("flush_no_done", {63'd0, saw_done}, 64'd0);

        // Asynchronous reset in the middle of an iteration.
        @(negedge clk);
        start = 1'b1; funct = 6'h18; operand_a = $urandom; operand_b = $urandom;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        $display("async reset -> busy=%0d done=%0d hi=%h lo=%h dbz=%0d",
                 busy, done, hi, lo, div_by_zero);
        check("async_reset_outs", {busy, done, div_by_zero, hi, lo}, 67'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("mult_3x4", 6'h18, 32'd3, 32'd4);
        check("mult_3x4_lo", {32'd0, lo}, 64'd12);

        for (int i = 0; i < 24; i++) begin
            logic [5:0]  rf;
            logic [31:0] ra, rb;
            rf = 6'h18 + 6'($urandom_range(0, 3));
            ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
            rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
            if ($urandom_range(0, 2) == 0) rb = rb >> $urandom_range(16, 31);
            run_op($sformatf("rand%0d", i), rf, ra, rb);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Multi-cycle multiply/divide sequencer attached beside the EXE-stage ALU. It accepts MULT/MULTU/DIV/DIVU requests from EXE and runs a 32-iteration shift-add multiply or restoring divide. It writes the 64-bit result into architectural HI/LO registers and holds a stall to the pipeline while it is busy. MFHI/MFLO are served from its hi/lo outputs by the EXE result mux.

## Interface
- No parameters; width fixed at 32.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request valid from EXE (instruction is a mul/div)
- funct  in  6  MIPS funct: 6'h18 MULT, 6'h19 MULTU, 6'h1A DIV, 6'h1B DIVU; other values ignored
- operand_a  in  32  rs value (multiplicand / dividend)
- operand_b  in  32  rt value (multiplier / divisor)
- flush  in  1  abort in-flight op (branch/exception flush)
- busy  out  1  registered; high whenever state != IDLE; pipeline stalls EXE on busy
- done  out  1  registered one-cycle pulse when HI/LO are updated
- hi  out  32  HI register (product[63:32] / remainder)
- lo  out  32  LO register (product[31:0] / quotient)
- div_by_zero  out  1  sticky flag; set by a DIV/DIVU with operand_b==0, cleared by the next accepted start

## Operation
- FSM states: IDLE, RUN, FIX.
- IDLE → RUN on start with a valid funct.
  - Latch abs(operand_a) and abs(operand_b); for unsigned ops, latch the operands as-is.
  - Latch the result signs. Product sign: a[31]^b[31]. Quotient sign: a[31]^b[31]. Remainder sign: a[31]. Sign bits are used only for signed ops.
  - Clear cnt to 0 and clear div_by_zero.
- DIV/DIVU with operand_b==0 goes IDLE → FIX directly; no iterations.
- RUN: one iteration per cycle; cnt increments 0..31. RUN → FIX on the edge where cnt==31.
  - Multiply: 64-bit accumulator, add-if-LSB then shift right.
  - Divide: restoring. Shift the remainder:quotient pair left, trial-subtract the divisor, keep the result if non-negative, set the quotient LSB.
- FIX (one cycle): apply two's-complement sign correction, write hi/lo, pulse done, return to IDLE.
  - Divide-by-zero result: hi = dividend (unmodified operand_a), lo = 32'hFFFF_FFFF, div_by_zero = 1.
- Arithmetic:
  - The unsigned magnitude of -2^31 is 2^31, which fits 32 unsigned bits.
  - DIV 0x80000000 / 0xFFFFFFFF yields lo=0x80000000, hi=0 with no special case.
- start in a non-IDLE state is ignored; EXE is stalled, so the request is held and re-presented. An invalid funct in IDLE is ignored.
- flush in RUN or FIX → IDLE next edge; hi/lo/div_by_zero are unchanged and done is not pulsed. flush in IDLE has no effect. flush and start in the same IDLE cycle: flush wins, the request is not accepted.
- hi/lo change only in FIX.

## Timing
- Reset (async, rst_n=0): state=IDLE, cnt=0, busy=0, done=0, hi=0, lo=0, div_by_zero=0, internal accumulators 0. Reset mid-operation discards the op.
- Accept edge E0 (start & IDLE).
  - busy is high from after E0 until after the FIX edge.
  - Normal ops: RUN at edges E1..E32, FIX at E33. hi/lo/done valid in the cycle after E33, when busy=0. Latency is 33 cycles.
  - Divide by zero: FIX at E1. Result valid after E1; latency is 1 cycle.
- done is high for exactly one cycle, coincident with busy falling.
- Back-to-back: a new start can be accepted on the same edge that done is high, since state is IDLE in that cycle.

## Structure
- Shared package (muldiv_pkg):
  - funct constants FUNCT_MULT/MULTU/DIV/DIVU/MFHI/MFLO
  - state enum {IDLE, RUN, FIX}
  - ITER_LAST = 5'd31
- One sub-module, muldiv_step: combinational single iteration. Inputs: mode, 64-bit accumulator, 32-bit operand. Output: next accumulator.
- The top level holds the FSM, counter, sign latches, and the HI/LO registers.

## Test plan
- MULT 7 × -3 (0x00000007, 0xFFFFFFFD) → after 33 cycles hi=0xFFFFFFFF, lo=0xFFFFFFEB, done one-cycle pulse; MULTU 0xFFFFFFFF × 2 → hi=1, lo=0xFFFFFFFE.
- DIVU 100/7 → lo=14, hi=2; DIV -7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000/-1 → lo=0x80000000, hi=0.
- DIV 5/0 → busy one cycle, hi=5, lo=0xFFFFFFFF, div_by_zero=1; next MULT 1×1 clears the flag, hi=0, lo=1.
- start pulsed every cycle during RUN with different operands → ignored; result matches the first op; second op accepted on the done cycle completes 33 cycles later.
- flush at cnt=10 after a prior result (hi=2, lo=14) → IDLE next edge, no done, hi/lo still 2/14.
- rst_n low at cnt=20 (async, mid-cycle) → all outputs 0 immediately; after release, a fresh MULT 3×4 gives lo=12.
